// File: rtl/uart_rx_cfg_if.sv
// Word-side handshake of uart_rx_cfg: received word plus its error flags, valid/ready.
interface uart_rx_cfg_if #(
  parameter int data_bits = 8
);
  logic                 rx_valid;
  logic                 rx_ready;
  logic [data_bits-1:0] rx_data;
  logic                 parity_err;
  logic                 frame_err;

  modport master (
    output rx_valid,
    output rx_data,
    output parity_err,
    output frame_err,
    input  rx_ready
  );

  modport slave (
    input  rx_valid,
    input  rx_data,
    input  parity_err,
    input  frame_err,
    output rx_ready
  );
endinterface

// File: rtl/uart_rx_cfg.sv
// Configurable async UART receiver with parity/framing/break/overrun reporting.
// Optional UART_RX_FIFO_EN: show-ahead word FIFO instead of a single holding register.
module uart_rx_cfg #(
  parameter int clk_freq     = 12000000,
  parameter int baud         = 115200,
  parameter int oversampling = 8,
  parameter int data_bits    = 8,
  parameter int parity       = 0,
  parameter int stop_bits    = 1,
  parameter int fifo_depth   = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rx,
  uart_rx_cfg_if.master m_if,
  output logic          overrun,
  output logic          break_det,
  output logic          rx_idle,
  output logic          rx_eop
);

  localparam int OSW     = $clog2(oversampling);
  localparam int GAP_MAX = 4 * oversampling;
  localparam int GW      = $clog2(GAP_MAX + 1);
  localparam logic [32:0] ACC_INC = 33'(baud * oversampling);
  localparam logic [32:0] ACC_MOD = 33'(clk_freq);
  localparam logic [OSW-1:0] MID  = OSW'(oversampling / 2 - 1);

  if (oversampling < 4 || (oversampling & (oversampling - 1)) != 0) begin : g_bad_os
    $error("oversampling must be a power of two >= 4");
  end
  if (fifo_depth < 2 || (fifo_depth & (fifo_depth - 1)) != 0) begin : g_bad_depth
    $error("fifo_depth must be a power of two >= 2");
  end

  typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP, ST_BRK} state_t;

  logic [32:0]          r_acc;
  logic [32:0]          w_acc_sum;
  logic                 r_os_tick;
  logic [1:0]           r_sync;
  logic [1:0]           r_flt;
  logic                 r_rx_bit;
  state_t               r_state;
  logic [OSW-1:0]       r_os_cnt;
  logic [3:0]           r_bit_cnt;
  logic [data_bits-1:0] r_shift;
  logic                 r_pbit;
  logic                 r_stop_low;
  logic                 r_stop_high;
  logic                 r_brk;
  logic [GW-1:0]        r_gap;
  logic                 r_idle;
  logic                 r_eop;
  logic                 r_ovr;

  logic w_sample, w_last_stop, w_stop_low, w_all_low, w_xor, w_perr, w_cmp;
  logic w_valid, w_pop;

  assign w_acc_sum = r_acc + ACC_INC;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc     <= '0;
      r_os_tick <= 1'b0;
      r_sync    <= '1;
      r_flt     <= '1;
      r_rx_bit  <= 1'b1;
    end else begin
      if (w_acc_sum >= ACC_MOD) begin
        r_acc     <= w_acc_sum - ACC_MOD;
        r_os_tick <= 1'b1;
      end else begin
        r_acc     <= w_acc_sum;
        r_os_tick <= 1'b0;
      end
      if (r_os_tick) begin
        r_sync <= {r_sync[0], rx};
        if (r_sync[1] && r_flt != 2'd3)
          r_flt <= r_flt + 2'd1;
        else if (!r_sync[1] && r_flt != 2'd0)
          r_flt <= r_flt - 2'd1;
        if (r_flt == 2'd3)
          r_rx_bit <= 1'b1;
        else if (r_flt == 2'd0)
          r_rx_bit <= 1'b0;
      end
    end
  end

  assign w_sample    = r_os_tick && (r_os_cnt == MID);
  assign w_last_stop = (r_state == ST_STOP) && w_sample && (r_bit_cnt == 4'(stop_bits - 1));
  assign w_stop_low  = r_stop_low | ~r_rx_bit;
  assign w_all_low   = (r_shift == '0) && !r_pbit && !r_stop_high && !r_rx_bit;
  assign w_xor       = (^r_shift) ^ r_pbit;
  assign w_perr      = (parity == 1) ? w_xor : (parity == 2) ? ~w_xor : 1'b0;
  assign w_cmp       = w_last_stop && !w_all_low;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_os_cnt    <= '0;
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_pbit      <= 1'b0;
      r_stop_low  <= 1'b0;
      r_stop_high <= 1'b0;
      r_brk       <= 1'b0;
    end else begin
      r_brk <= 1'b0;
      if (r_state == ST_IDLE)
        r_os_cnt <= '0;
      else if (r_os_tick)
        r_os_cnt <= r_os_cnt + OSW'(1);
      case (r_state)
        ST_IDLE: begin
          if (!r_rx_bit) begin
            r_state     <= ST_START;
            r_bit_cnt   <= '0;
            r_pbit      <= 1'b0;
            r_stop_low  <= 1'b0;
            r_stop_high <= 1'b0;
          end
        end
        ST_START: begin
          if (w_sample)
            r_state <= r_rx_bit ? ST_IDLE : ST_DATA;
        end
        ST_DATA: begin
          if (w_sample) begin
            r_shift <= {r_rx_bit, r_shift[data_bits-1:1]};
            if (r_bit_cnt == 4'(data_bits - 1)) begin
              r_bit_cnt <= '0;
              r_state   <= (parity != 0) ? ST_PARITY : ST_STOP;
            end else begin
              r_bit_cnt <= r_bit_cnt + 4'd1;
            end
          end
        end
        ST_PARITY: begin
          if (w_sample) begin
            r_pbit  <= r_rx_bit;
            r_state <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (w_sample) begin
            r_stop_low  <= w_stop_low;
            r_stop_high <= r_stop_high | r_rx_bit;
            if (w_last_stop) begin
              if (w_all_low) begin
                r_state <= ST_BRK;
                r_brk   <= 1'b1;
              end else begin
                r_state <= ST_IDLE;
              end
            end else begin
              r_bit_cnt <= r_bit_cnt + 4'd1;
            end
          end
        end
        ST_BRK: begin
          if (r_rx_bit)
            r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_gap  <= '0;
      r_idle <= 1'b0;
      r_eop  <= 1'b0;
    end else begin
      r_eop <= 1'b0;
      if (r_state != ST_IDLE) begin
        r_gap  <= '0;
        r_idle <= 1'b0;
      end else if (r_os_tick && r_gap != GW'(GAP_MAX)) begin
        r_gap <= r_gap + GW'(1);
        if (r_gap == GW'(GAP_MAX - 1)) begin
          r_idle <= 1'b1;
          r_eop  <= 1'b1;
        end
      end
    end
  end

  assign w_pop = w_valid & m_if.rx_ready;

`ifdef UART_RX_FIFO_EN
  localparam int AW = $clog2(fifo_depth);

  logic [data_bits+1:0] r_mem [fifo_depth];
  logic [AW:0]          r_wr;
  logic [AW:0]          r_rd;
  logic                 w_full;
  logic                 w_push;

  assign w_valid = (r_wr != r_rd);
  assign w_full  = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
  // A pop in the completion cycle frees the slot the new word needs.
  assign w_push  = w_cmp && (!w_full || w_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_ovr <= 1'b0;
      for (int unsigned i = 0; i < fifo_depth; i++)
        r_mem[i] <= '0;
    end else begin
      r_ovr <= w_cmp && !w_push;
      if (w_push) begin
        r_mem[r_wr[AW-1:0]] <= {w_perr, w_stop_low, r_shift};
        r_wr <= r_wr + (AW+1)'(1);
      end
      if (w_pop)
        r_rd <= r_rd + (AW+1)'(1);
    end
  end

  assign m_if.rx_valid   = w_valid;
  assign m_if.parity_err = r_mem[r_rd[AW-1:0]][data_bits+1];
  assign m_if.frame_err  = r_mem[r_rd[AW-1:0]][data_bits];
  assign m_if.rx_data    = r_mem[r_rd[AW-1:0]][data_bits-1:0];
`else
  logic                 r_valid;
  logic [data_bits-1:0] r_data;
  logic                 r_perr;
  logic                 r_ferr;

  assign w_valid = r_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_perr  <= 1'b0;
      r_ferr  <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      r_ovr <= 1'b0;
      if (w_cmp && (!r_valid || w_pop)) begin
        r_valid <= 1'b1;
        r_data  <= r_shift;
        r_perr  <= w_perr;
        r_ferr  <= w_stop_low;
      end else begin
        if (w_cmp)
          r_ovr <= 1'b1;
        if (w_pop)
          r_valid <= 1'b0;
      end
    end
  end

  assign m_if.rx_valid   = r_valid;
  assign m_if.parity_err = r_perr;
  assign m_if.frame_err  = r_ferr;
  assign m_if.rx_data    = r_data;
`endif

  assign overrun   = r_ovr;
  assign break_det = r_brk;
  assign rx_idle   = r_idle;
  assign rx_eop    = r_eop;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed bench for uart_rx_cfg: three instances (8N1, 8E1, 7O2) on separate lines.
module tb_uart_rx_cfg;
  localparam int CLK_FREQ = 1000000;
  localparam int BAUD     = 31250;
  localparam int OS       = 8;
  localparam int BIT_CLKS = CLK_FREQ / BAUD;
`ifdef UART_RX_FIFO_EN
  localparam int DEPTH = 4;
`else
  localparam int DEPTH = 1;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] rx_l;
  logic [2:0] ovr, brk, idle, eop;

  uart_rx_cfg_if #(.data_bits(8)) if_a ();
  uart_rx_cfg_if #(.data_bits(8)) if_b ();
  uart_rx_cfg_if #(.data_bits(7)) if_c ();

  uart_rx_cfg #(.clk_freq(CLK_FREQ), .baud(BAUD), .oversampling(OS), .data_bits(8),
                .parity(0), .stop_bits(1), .fifo_depth(4)) u_a (
    .clk(clk), .rst(rst), .rx(rx_l[0]), .m_if(if_a), .overrun(ovr[0]),
    .break_det(brk[0]), .rx_idle(idle[0]), .rx_eop(eop[0]));
  uart_rx_cfg #(.clk_freq(CLK_FREQ), .baud(BAUD), .oversampling(OS), .data_bits(8),
                .parity(1), .stop_bits(1), .fifo_depth(4)) u_b (
    .clk(clk), .rst(rst), .rx(rx_l[1]), .m_if(if_b), .overrun(ovr[1]),
    .break_det(brk[1]), .rx_idle(idle[1]), .rx_eop(eop[1]));
  uart_rx_cfg #(.clk_freq(CLK_FREQ), .baud(BAUD), .oversampling(OS), .data_bits(7),
                .parity(2), .stop_bits(2), .fifo_depth(4)) u_c (
    .clk(clk), .rst(rst), .rx(rx_l[2]), .m_if(if_c), .overrun(ovr[2]),
    .break_det(brk[2]), .rx_idle(idle[2]), .rx_eop(eop[2]));

  always #5 clk = ~clk;

  int         checks = 0;
  int         fails  = 0;
  int         n_acc[3] = '{default: 0};
  int         n_ovr[3] = '{default: 0};
  int         n_brk[3] = '{default: 0};
  int         n_eop[3] = '{default: 0};
  logic [8:0] cap_d[3];
  logic       cap_p[3];
  logic       cap_f[3];

  always @(negedge clk) begin
    if (if_a.rx_valid && if_a.rx_ready) begin
      n_acc[0]++; cap_d[0] = {1'b0, if_a.rx_data}; cap_p[0] = if_a.parity_err; cap_f[0] = if_a.frame_err;
    end
    if (if_b.rx_valid && if_b.rx_ready) begin
      n_acc[1]++; cap_d[1] = {1'b0, if_b.rx_data}; cap_p[1] = if_b.parity_err; cap_f[1] = if_b.frame_err;
    end
    if (if_c.rx_valid && if_c.rx_ready) begin
      n_acc[2]++; cap_d[2] = {2'b0, if_c.rx_data}; cap_p[2] = if_c.parity_err; cap_f[2] = if_c.frame_err;
    end
    for (int k = 0; k < 3; k++) begin
      if (ovr[k]) n_ovr[k]++;
      if (brk[k]) n_brk[k]++;
      if (eop[k]) n_eop[k]++;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic cur_valid(input int s);
    case (s)
      0:       return if_a.rx_valid;
      1:       return if_b.rx_valid;
      default: return if_c.rx_valid;
    endcase
  endfunction

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // A low final stop bit is released just after its mid-bit sample, so the
  // re-armed start detector sees a clean high line instead of a racing edge.
  task automatic send_frame(input int sel, input logic [8:0] d, input logic pb, input logic [1:0] sv);
    int nb, ns;
    bit par;
    nb  = (sel == 2) ? 7 : 8;
    ns  = (sel == 2) ? 2 : 1;
    par = (sel != 0);
    rx_l[sel] = 1'b0;
    wait_clks(BIT_CLKS);
    for (int i = 0; i < nb; i++) begin
      rx_l[sel] = d[i];
      wait_clks(BIT_CLKS);
    end
    if (par) begin
      rx_l[sel] = pb;
      wait_clks(BIT_CLKS);
    end
    for (int i = 0; i < ns; i++) begin
      rx_l[sel] = sv[i];
      if (!sv[i] && i == ns - 1) wait_clks(BIT_CLKS * 5 / 8);
      else                       wait_clks(BIT_CLKS);
    end
    rx_l[sel] = 1'b1;
  endtask

  typedef struct {
    int         sel;
    logic [8:0] d;
    logic       pb;
    logic [1:0] sv;
    logic [8:0] ed;
    logic       ep;
    logic       ef;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int b_acc, b_ovr, b_brk, b_eop;
    logic [8:0] w_exp;

    vecs[0] = '{0, 9'h0A5, 1'b0, 2'b01, 9'h0A5, 1'b0, 1'b0};
    vecs[1] = '{1, 9'h003, 1'b1, 2'b01, 9'h003, 1'b1, 1'b0};
    vecs[2] = '{2, 9'h055, 1'b1, 2'b11, 9'h055, 1'b0, 1'b0};
    vecs[3] = '{0, 9'h03C, 1'b0, 2'b00, 9'h03C, 1'b0, 1'b1};
    vecs[4] = '{1, 9'h081, 1'b0, 2'b01, 9'h081, 1'b0, 1'b0};
    vecs[5] = '{2, 9'h000, 1'b0, 2'b11, 9'h000, 1'b1, 1'b0};
    vecs[6] = '{2, 9'h07F, 1'b0, 2'b01, 9'h07F, 1'b0, 1'b1};
    vecs[7] = '{0, 9'h000, 1'b0, 2'b01, 9'h000, 1'b0, 1'b0};
    vecs[8] = '{0, 9'h0FF, 1'b0, 2'b01, 9'h0FF, 1'b0, 1'b0};
    vecs[9] = '{1, 9'h0FF, 1'b1, 2'b01, 9'h0FF, 1'b1, 1'b0};

    rst = 1'b1;
    rx_l = '1;
    if_a.rx_ready = 1'b1;
    if_b.rx_ready = 1'b1;
    if_c.rx_ready = 1'b1;
    wait_clks(4);
    chk("rst_valid_a", {31'b0, if_a.rx_valid}, 0);
    chk("rst_data_a", {24'b0, if_a.rx_data}, 0);
    chk("rst_perr_a", {31'b0, if_a.parity_err}, 0);
    chk("rst_ferr_a", {31'b0, if_a.frame_err}, 0);
    chk("rst_valid_c", {31'b0, if_c.rx_valid}, 0);
    chk("rst_ovr", {29'b0, ovr}, 0);
    chk("rst_brk", {29'b0, brk}, 0);
    chk("rst_idle", {29'b0, idle}, 0);
    chk("rst_eop", {29'b0, eop}, 0);
    rst = 1'b0;
    wait_clks(8 * BIT_CLKS);
    chk("idle_after_rst", {29'b0, idle}, 3'b111);

    for (int i = 0; i < 10; i++) begin
      b_acc = n_acc[vecs[i].sel];
      b_brk = n_brk[vecs[i].sel];
      send_frame(vecs[i].sel, vecs[i].d, vecs[i].pb, vecs[i].sv);
      wait_clks(3 * BIT_CLKS);
      chk($sformatf("v%0d_count", i), n_acc[vecs[i].sel] - b_acc, 1);
      chk($sformatf("v%0d_data", i), {23'b0, cap_d[vecs[i].sel]}, {23'b0, vecs[i].ed});
      chk($sformatf("v%0d_perr", i), {31'b0, cap_p[vecs[i].sel]}, {31'b0, vecs[i].ep});
      chk($sformatf("v%0d_ferr", i), {31'b0, cap_f[vecs[i].sel]}, {31'b0, vecs[i].ef});
      chk($sformatf("v%0d_nobrk", i), n_brk[vecs[i].sel] - b_brk, 0);
      chk($sformatf("v%0d_valid_low", i), {31'b0, cur_valid(vecs[i].sel)}, 0);
    end

    // Break: 12 bit times low on the 8N1 line, then idle detection.
    b_acc = n_acc[0];
    b_brk = n_brk[0];
    rx_l[0] = 1'b0;
    wait_clks(12 * BIT_CLKS);
    chk("brk_pulse", n_brk[0] - b_brk, 1);
    chk("brk_no_word", n_acc[0] - b_acc, 0);
    b_eop = n_eop[0];
    rx_l[0] = 1'b1;
    wait_clks(BIT_CLKS);
    chk("brk_idle_early", {31'b0, idle[0]}, 0);
    wait_clks(7 * BIT_CLKS);
    chk("brk_eop_once", n_eop[0] - b_eop, 1);
    chk("brk_idle_set", {31'b0, idle[0]}, 1);

    // One-tick glitch must be filtered out.
    b_acc = n_acc[0];
    b_brk = n_brk[0];
    rx_l[0] = 1'b0;
    wait_clks(CLK_FREQ / (BAUD * OS));
    rx_l[0] = 1'b1;
    wait_clks(20 * BIT_CLKS);
    chk("glitch_no_word", n_acc[0] - b_acc, 0);
    chk("glitch_no_brk", n_brk[0] - b_brk, 0);

    // Overrun: consumer stalled, storage fills, one extra word is dropped.
    if_a.rx_ready = 1'b0;
    b_ovr = n_ovr[0];
    for (int w = 0; w <= DEPTH; w++) begin
      w_exp = 9'(8'h11 * (w + 1));
      send_frame(0, w_exp, 1'b0, 2'b01);
      wait_clks(2 * BIT_CLKS);
    end
    wait_clks(BIT_CLKS);
    chk("ovr_once", n_ovr[0] - b_ovr, 1);
    for (int w = 0; w < DEPTH; w++) begin
      w_exp = 9'(8'h11 * (w + 1));
      chk($sformatf("ovr_hold_valid%0d", w), {31'b0, if_a.rx_valid}, 1);
      chk($sformatf("ovr_hold_data%0d", w), {24'b0, if_a.rx_data}, {23'b0, w_exp});
      if_a.rx_ready = 1'b1;
      @(negedge clk);
      if_a.rx_ready = 1'b0;
    end
    @(negedge clk);
    chk("ovr_drained", {31'b0, if_a.rx_valid}, 0);
    if_a.rx_ready = 1'b1;
    wait_clks(2 * BIT_CLKS);

    // Reset in the middle of a byte, then a clean word.
    b_acc = n_acc[0];
    w_exp = 9'h05A;
    rx_l[0] = 1'b0;
    wait_clks(BIT_CLKS);
    for (int i = 0; i < 4; i++) begin
      rx_l[0] = w_exp[i];
      wait_clks(BIT_CLKS);
    end
    rst = 1'b1;
    rx_l[0] = 1'b1;
    wait_clks(3);
    chk("rstmid_valid", {31'b0, if_a.rx_valid}, 0);
    rst = 1'b0;
    wait_clks(15 * BIT_CLKS);
    chk("rstmid_no_word", n_acc[0] - b_acc, 0);
    send_frame(0, w_exp, 1'b0, 2'b01);
    wait_clks(3 * BIT_CLKS);
    chk("post_rst_count", n_acc[0] - b_acc, 1);
    chk("post_rst_data", {23'b0, cap_d[0]}, 32'h5A);
    chk("post_rst_flags", {30'b0, cap_p[0], cap_f[0]}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails + 1);
    $fatal(1);
  end

endmodule
